// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: a handshaked binary value is converted to BASE digits
// by bit-serial restoring division, then scanned out one digit at a time with PWM dimming.
module seg7_scan_driver #(
   parameter int BASE        = 16,
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 16,
   parameter int FREQ_IN     = 12000000,
   parameter int FREQ_DISP   = 1000,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit SEL_ACT_LOW = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [DIGITS-1:0] dp_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        bright_i,
   output logic [7:0]        segment_o,
   output logic [DIGITS-1:0] select_o,
   output logic              overflow_o
);
   localparam int PRE_RAW = FREQ_IN / (FREQ_DISP * DIGITS * 16);
   localparam int PRE_DIV = (PRE_RAW < 1) ? 1 : PRE_RAW;
   localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam int BIT_W   = $clog2(DATA_W + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [4:0] BASE_V = 5'(BASE);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

   state_t                  state, state_n;
   logic [DATA_W-1:0]       dividend;
   logic [4:0]              rem;
   logic [BIT_W-1:0]        bit_cnt;
   logic [IDX_W-1:0]        dig_cnt;
   logic [DIGITS-1:0][3:0]  shadow, disp_val;
   logic [DIGITS-1:0]       dp_sh, disp_dp;
   logic                    ovf_q;
   logic                    accept, div_step, store_step, commit;
   logic [4:0]              rem_sh, rem_nx;
   logic                    q_bit;

   // Handshake: a transfer happens at a posedge where valid_i && ready_o; data_i/dp_i need only
   // be stable in that cycle, and valid_i while busy (ready_o=0) is dropped, not queued.
   assign ready_o    = (state == S_IDLE);
   assign overflow_o = ovf_q;

   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      div_step   = 1'b0;
      store_step = 1'b0;
      commit     = 1'b0;
      case (state)
         S_IDLE: if (valid_i) begin
            accept  = 1'b1;
            state_n = S_CONV;
         end
         S_CONV: if (bit_cnt == BIT_W'(DATA_W)) begin
            store_step = 1'b1;
            if (dig_cnt == IDX_W'(DIGITS - 1)) state_n = S_COMMIT;
         end else begin
            div_step = 1'b1;
         end
         S_COMMIT: begin
            commit  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // One restoring step: shift the dividend MSB into the remainder, subtract BASE if it fits.
   assign rem_sh = {rem[3:0], dividend[DATA_W-1]};
   assign q_bit  = (rem_sh >= BASE_V);
   assign rem_nx = q_bit ? (rem_sh - BASE_V) : rem_sh;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         dividend <= '0;
         rem      <= '0;
         bit_cnt  <= '0;
         dig_cnt  <= '0;
         shadow   <= '0;
         dp_sh    <= '0;
         disp_val <= '0;
         disp_dp  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            dividend <= data_i;
            dp_sh    <= dp_i;
            rem      <= '0;
            bit_cnt  <= '0;
            dig_cnt  <= '0;
         end
         if (div_step) begin
            dividend <= (dividend << 1) | DATA_W'(q_bit);
            rem      <= rem_nx;
            bit_cnt  <= bit_cnt + BIT_W'(1);
         end
         if (store_step) begin
            for (int k = 0; k < DIGITS; k++)
               if (dig_cnt == IDX_W'(k)) shadow[k] <= rem[3:0];
            rem     <= '0;
            bit_cnt <= '0;
            dig_cnt <= dig_cnt + IDX_W'(1);
         end
         if (commit) begin
            disp_val <= shadow;
            disp_dp  <= dp_sh;
            ovf_q    <= (dividend != '0);
         end
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   logic [PRE_W-1:0]  presc;
   logic              sub_tick;
   logic [3:0]        pwm_cnt, bright_q, bright_eff;
   logic [IDX_W-1:0]  scan_idx;
   logic [3:0]        cur_val;
   logic              cur_dp, nz_above, blank, lit;
   logic [7:0]        seg_act, seg_q;
   logic [DIGITS-1:0] sel_act, sel_q;

   assign sub_tick   = (presc == PRE_W'(PRE_DIV - 1));
   // The duty for a PWM period is taken from bright_i as the count passes 0.
   assign bright_eff = (pwm_cnt == 4'd0) ? bright_i : bright_q;
   assign segment_o  = seg_q;
   assign select_o   = sel_q;

   always_comb begin
      cur_val  = '0;
      cur_dp   = 1'b0;
      nz_above = 1'b0;
      sel_act  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (scan_idx == IDX_W'(k)) begin
            cur_val    = disp_val[k];
            cur_dp     = disp_dp[k];
            sel_act[k] = 1'b1;
         end
         if ((IDX_W'(k) >= scan_idx) && (disp_val[k] != 4'd0)) nz_above = 1'b1;
      end
      blank = (scan_idx != '0) && !nz_above && !ovf_q;
      if (ovf_q)      seg_act = {cur_dp, 7'h40};
      else if (blank) seg_act = {cur_dp, 7'h00};
      else            seg_act = {cur_dp, glyph(cur_val)};
      lit = (pwm_cnt < bright_eff);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc    <= '0;
         pwm_cnt  <= '0;
         scan_idx <= '0;
         bright_q <= '0;
         seg_q    <= {8{SEG_ACT_LOW}};
         sel_q    <= {DIGITS{SEL_ACT_LOW}};
      end else begin
         presc <= sub_tick ? '0 : presc + PRE_W'(1);
         if (pwm_cnt == 4'd0) bright_q <= bright_i;
         if (sub_tick) begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (pwm_cnt == 4'd15)
               scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
         end
         seg_q <= (lit ? seg_act : 8'h00) ^ {8{SEG_ACT_LOW}};
         sel_q <= (lit ? sel_act : '0) ^ {DIGITS{SEL_ACT_LOW}};
      end
   end
endmodule
